// File: rtl/instr_issue_sched_if.sv
// Issue-scheduler bus bundle: requester ports, issue port, writeback, flush and status.
// master = environment driving requests and writebacks, slave = the scheduler.
interface instr_issue_sched_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned REG_WIDTH = 5,
  parameter int unsigned OP_WIDTH  = 7
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*REG_WIDTH-1:0] req_rs0;
  logic [NUM_REQ*REG_WIDTH-1:0] req_rs1;
  logic [NUM_REQ*REG_WIDTH-1:0] req_rd;
  logic [NUM_REQ*OP_WIDTH-1:0]  req_opcode;

  logic                         issue_valid;
  logic [REG_WIDTH-1:0]         issue_rs0;
  logic [REG_WIDTH-1:0]         issue_rs1;
  logic [REG_WIDTH-1:0]         issue_rd;
  logic [OP_WIDTH-1:0]          issue_opcode;

  logic                         wb_valid;
  logic [REG_WIDTH-1:0]         wb_rd;

  logic                         flush_req;
  logic                         flush_done;
  logic                         sb_busy;

  modport master (
    output req_valid, req_rs0, req_rs1, req_rd, req_opcode,
    output wb_valid, wb_rd, flush_req,
    input  req_ready, issue_valid, issue_rs0, issue_rs1, issue_rd, issue_opcode,
    input  flush_done, sb_busy
  );

  modport slave (
    input  req_valid, req_rs0, req_rs1, req_rd, req_opcode,
    input  wb_valid, wb_rd, flush_req,
    output req_ready, issue_valid, issue_rs0, issue_rs1, issue_rd, issue_opcode,
    output flush_done, sb_busy
  );
endinterface

// File: rtl/instr_issue_sched.sv
// Round-robin instruction issue scheduler with RAW/WAW register scoreboard and flush/drain FSM.
// Optional ISSUE_SCHED_PERF_EN adds a saturating stall counter output perf_stall_cnt.
module instr_issue_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned REG_WIDTH = 5,
  parameter int unsigned OP_WIDTH  = 7
) (
  input  logic                clk,
  input  logic                reset,
  instr_issue_sched_if.slave  bus
`ifdef ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NUM_REGS = 1 << REG_WIDTH;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REGS-1:0]  sb_q, sb_d;
  logic [NUM_REGS-1:0]  wb_mask, busy_view;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   eligible;
  logic [PTR_W:0]       pick;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  logic                 flush_done_d;

  logic                 issue_valid_q;
  logic [REG_WIDTH-1:0] issue_rs0_q, issue_rs1_q, issue_rd_q;
  logic [OP_WIDTH-1:0]  issue_opcode_q;
  logic                 flush_done_q;

  logic [REG_WIDTH-1:0] rs0_a [NUM_REQ];
  logic [REG_WIDTH-1:0] rs1_a [NUM_REQ];
  logic [REG_WIDTH-1:0] rd_a  [NUM_REQ];
  logic [OP_WIDTH-1:0]  op_a  [NUM_REQ];

  // Unpack the flat requester buses into per-requester fields
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rs0_a[g] = bus.req_rs0[g*REG_WIDTH +: REG_WIDTH];
    assign rs1_a[g] = bus.req_rs1[g*REG_WIDTH +: REG_WIDTH];
    assign rd_a[g]  = bus.req_rd[g*REG_WIDTH +: REG_WIDTH];
    assign op_a[g]  = bus.req_opcode[g*OP_WIDTH +: OP_WIDTH];
  end

  // First eligible requester at or after ptr, wrapping; returns {found, index}
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                              input logic [PTR_W-1:0]   ptr);
    logic [PTR_W:0] res;
    int unsigned    idx;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!res[PTR_W] && elig[PTR_W'(idx)]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  // Writeback retiring this cycle is bypassed into the hazard check; r0 is never busy
  always_comb begin
    wb_mask = '0;
    if (bus.wb_valid) wb_mask[bus.wb_rd] = 1'b1;
    busy_view    = sb_q & ~wb_mask;
    busy_view[0] = 1'b0;
  end

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (state_q == ST_RUN) &&
                    !busy_view[rs0_a[i]] && !busy_view[rs1_a[i]] && !busy_view[rd_a[i]];
    end
  end

  assign pick        = rr_pick(eligible, rr_ptr_q);
  assign grant_found = pick[PTR_W];
  assign grant_idx   = pick[PTR_W-1:0];

  assign bus.req_ready = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_found) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Clear on writeback first, then set for the granted destination so set wins
  always_comb begin
    sb_d = sb_q;
    if (bus.wb_valid) sb_d[bus.wb_rd] = 1'b0;
    if (grant_found)  sb_d[rd_a[grant_idx]] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Flush/drain next-state logic
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_RUN:   if (bus.flush_req) state_d = ST_DRAIN;
      ST_DRAIN: if (sb_d == '0)    state_d = ST_DONE;
      ST_DONE:  state_d = bus.flush_req ? ST_DRAIN : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    flush_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q           <= '0;
      rr_ptr_q       <= '0;
      issue_valid_q  <= 1'b0;
      issue_rs0_q    <= '0;
      issue_rs1_q    <= '0;
      issue_rd_q     <= '0;
      issue_opcode_q <= '0;
      flush_done_q   <= 1'b0;
    end else begin
      sb_q          <= sb_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= grant_found;
      flush_done_q  <= flush_done_d;
      if (grant_found) begin
        issue_rs0_q    <= rs0_a[grant_idx];
        issue_rs1_q    <= rs1_a[grant_idx];
        issue_rd_q     <= rd_a[grant_idx];
        issue_opcode_q <= op_a[grant_idx];
      end
    end
  end

  assign bus.issue_valid  = issue_valid_q;
  assign bus.issue_rs0    = issue_rs0_q;
  assign bus.issue_rs1    = issue_rs1_q;
  assign bus.issue_rd     = issue_rd_q;
  assign bus.issue_opcode = issue_opcode_q;
  assign bus.flush_done   = flush_done_q;
  assign bus.sb_busy      = |sb_q;

`ifdef ISSUE_SCHED_PERF_EN
  logic [31:0] stall_cnt_q;

  // Cycles with pending work in RUN that could not issue; saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((|bus.req_valid) && (state_q == ST_RUN) && !grant_found &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
